// File: rtl/mem_stage_lsu_if.sv
//============================================================================
// mem_stage_lsu_if : data-memory req/ack bus between the LSU and dmem
// Rev 1.0
//============================================================================
`default_nettype none

interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
//============================================================================
// mem_stage_lsu : MEM-stage load/store unit with variable-latency dmem port
// Rev 1.0
//============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              req_valid,
    input  wire logic              req_write,
    input  wire logic [1:0]        req_size,
    input  wire logic              req_signed,
    input  wire logic [ADDR_W-1:0] req_addr,
    input  wire logic [31:0]       req_wdata,
    output logic                   stall,
    output logic [31:0]            rdata,
    output logic                   rdata_valid,
    output logic                   fault,
    mem_stage_lsu_if.master        dmem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]      lane_q;
    logic [1:0]      size_q;
    logic            signed_q;

    logic            req_legal;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_ext;

    always_comb begin
        req_legal = 1'b0;
        be_c      = 4'b1111;
        wdata_c   = req_wdata;
        case (req_size)
            2'b00: begin
                req_legal = 1'b1;
                be_c      = 4'b0001 << req_addr[1:0];
                wdata_c   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_legal = ~req_addr[0];
                be_c      = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c   = {2{req_wdata[15:0]}};
            end
            2'b10:   req_legal = (req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
        if (!req_write) begin
            wdata_c = 32'h0;
        end
    end

    // Lane select uses the address/size captured at accept, not the live inputs
    always_comb begin
        byte_sel = 8'h0;
        case (lane_q)
            2'b00:   byte_sel = dmem.dmem_rdata[7:0];
            2'b01:   byte_sel = dmem.dmem_rdata[15:8];
            2'b10:   byte_sel = dmem.dmem_rdata[23:16];
            default: byte_sel = dmem.dmem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            2'b01:   load_ext = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // Gated by reset so the hazard unit sees no stall while held in reset
    assign stall = (state == S_WAIT) || ((state == S_IDLE) && req_valid && reset);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            tmo_cnt         <= '0;
            lane_q          <= 2'b00;
            size_q          <= 2'b00;
            signed_q        <= 1'b0;
            rdata           <= 32'h0;
            rdata_valid     <= 1'b0;
            fault           <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= 4'b0000;
            dmem.dmem_wdata <= 32'h0;
        end else begin
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= req_write;
                            dmem.dmem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            dmem.dmem_be    <= be_c;
                            dmem.dmem_wdata <= wdata_c;
                            lane_q          <= req_addr[1:0];
                            size_q          <= req_size;
                            signed_q        <= req_signed;
                            tmo_cnt         <= '0;
                            state           <= S_WAIT;
                        end else begin
                            fault       <= 1'b1;
                            rdata_valid <= 1'b1;
                            rdata       <= 32'h0;
                            state       <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        rdata         <= dmem.dmem_we ? 32'h0 : load_ext;
                        rdata_valid   <= 1'b1;
                        state         <= S_DONE;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                        dmem.dmem_req <= 1'b0;
                        rdata         <= 32'h0;
                        fault         <= 1'b1;
                        rdata_valid   <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the pipelined ARM core.
- Consumes the EX/MEM outputs (ALUOutM address, WriteDataM, MemWriteM/MemtoRegM) and drives a variable-latency data memory through a req/ack handshake.
- Returns aligned, extended read data to the MEM/WB register.
- Raises a stall to the hazard unit while an access is outstanding. Supports word, halfword and byte accesses, with sign/zero extension on loads.

Parameters:
- ADDR_W, 32, address width in bits.
- TIMEOUT, 255, maximum cycles in WAIT without dmem_ack before the access is aborted with a fault; counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  MEM-stage access request (MemWriteM | MemtoRegM after condition check).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  sign-extend load result (byte/half only).
- req_addr  input  ADDR_W  byte address (ALUOutM).
- req_wdata  input  32  store data (WriteDataM), lane-0 aligned.
- stall  output  1  to hazard unit; holds F/D/E/M stages.
- rdata  output  32  extended load data to MEM/WB.
- rdata_valid  output  1  one-cycle pulse: access complete.
- fault  output  1  one-cycle pulse with rdata_valid: misaligned, reserved size, or timeout.
- dmem_req  output  1  memory request, held until ack.
- dmem_we  output  1  memory write enable.
- dmem_addr  output  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00}).
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_ack  input  1  memory done; dmem_rdata valid this cycle for loads.
- dmem_rdata  input  32  memory read word.

Behaviour:
- **Reset** (reset=0, async): state IDLE, timeout counter 0; all outputs 0 (stall, rdata, rdata_valid, fault, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata). A reset mid-WAIT drops dmem_req immediately. An ack arriving after reset is ignored.
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE, req_valid=1:**
  - stall=1 (combinational).
  - If aligned and size legal: register dmem_we/addr/be/wdata, clear counter, go to WAIT.
  - If illegal: set fault flag, go to DONE without issuing a memory request.
  - Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- **IDLE, req_valid=0:** stall=0; remain in IDLE.
- **WAIT:**
  - dmem_req=1; stall=1; dmem_* held stable.
  - On dmem_ack: capture the extended load data into rdata, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: set fault, rdata=0, go to DONE; dmem_req deasserts on that transition.
- **DONE (one cycle):** stall=0, rdata_valid=1, fault=flag; dmem_req=0; go to IDLE. rdata holds until the next capture.
- **Latency:** minimum 3 cycles from req_valid (IDLE→WAIT→DONE) with ack in the first WAIT cycle; stall is high for exactly (cycles in IDLE-accept + WAIT).
- **Byte enables:** byte = 4'b0001<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- **Store data:** byte replicated {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged. Loads drive be per size, and dmem_wdata=0.
- **Load extract:**
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - Extend to 32 bits: sign-extend if req_signed, else zero-extend.
  - Word loads ignore req_signed.
- **Stores:** rdata_valid still pulses in DONE; rdata=0.
- **Input sampling:** req_* are sampled only in IDLE. Changes or deassertion of req_valid during WAIT/DONE (flush) are ignored, and the access completes; stores are never torn.
- **Spurious ack:** dmem_ack outside WAIT is ignored.
- **Back-to-back:** a new req_valid in the cycle after DONE is accepted normally (IDLE).

Test Plan:
- **Word load:** req addr=0x100, size=10, ack after 2 WAIT cycles, dmem_rdata=0xDEADBEEF → dmem_be=1111, stall high 3 cycles, rdata=0xDEADBEEF, rdata_valid 1 pulse, fault=0.
- **Signed/unsigned byte load:** addr=0x103, dmem_rdata=0x80112233 → be=1000; signed rdata=0xFFFFFF80; unsigned rdata=0x00000080.
- **Halfword store:** addr=0x202, wdata=0x0000ABCD → dmem_we=1, dmem_addr=0x200, be=1100, dmem_wdata=0xABCDABCD, fields stable until ack.
- **Misaligned word:** addr=0x101 → no dmem_req ever; fault=1 with rdata_valid one cycle after request; stall high 1 cycle. Size 11 → same response.
- **Timeout:** TIMEOUT=4, no ack → dmem_req high exactly 5 WAIT cycles, then fault+rdata_valid, rdata=0, back to IDLE.
- **Reset/flush:**
  - reset low mid-WAIT → dmem_req and stall 0 immediately; subsequent ack produces no rdata_valid.
  - req_valid dropped in WAIT → access still completes on ack with one rdata_valid pulse.
